// File: rtl/regfile_pkg.sv
// Shared constants, requester encodings and writeback request type for the
// register-file write arbiter.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and the issue-stage
// hazard compare against the registered busy vector (no forwarding).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS_P = NUM_REGS,
    parameter int ADDR_W_P   = ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [ADDR_W_P-1:0]   issue_rs1,
    input  logic [ADDR_W_P-1:0]   issue_rs2,
    input  logic [ADDR_W_P-1:0]   issue_rd,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic                  issue_use_rd,
    output logic                  issue_ready,
    input  logic                  clr_en,
    input  logic [ADDR_W_P-1:0]   clr_rd,
    output logic [NUM_REGS_P-1:0] busy
);

    logic                  hazard;
    logic                  set_en;
    logic [NUM_REGS_P-1:0] busy_next;

    // busy[0] is held at zero, so index 0 can never produce a hazard.
    assign hazard = (issue_use_rs1 && busy[issue_rs1]) ||
                    (issue_use_rs2 && busy[issue_rs2]) ||
                    (issue_use_rd  && busy[issue_rd]);

    assign issue_ready = !issue_valid || !hazard;
    assign set_en      = issue_valid && issue_ready && issue_use_rd &&
                         (issue_rd != '0);

    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        // Applied after the clear: a newer producer is in flight.
        if (set_en) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_next;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// memory writeback; optional counters under REGFILE_ARB_STATS_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic                issue_use_rd,
    output logic                issue_ready,
    output logic [ADDR_W-1:0]   wr_rd,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
`ifdef REGFILE_ARB_STATS_EN
    output logic [31:0]         conflict_count,
    output logic [31:0]         stall_count,
`endif
    output logic [NUM_REGS-1:0] busy
);

    logic    rr_ptr;
    logic    contended;
    logic    any_grant;
    logic    do_write;
    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t sel_req;

    assign alu_req   = '{rd: alu_rd, data: alu_data};
    assign mem_req   = '{rd: mem_rd, data: mem_data};
    assign contended = alu_valid && mem_valid;

    // Ready is a function of the valids and the pointer only.
    assign alu_ready = alu_valid && (!mem_valid || (rr_ptr == REQ_ALU));
    assign mem_ready = mem_valid && (!alu_valid || (rr_ptr == REQ_MEM));
    assign any_grant = alu_ready || mem_ready;
    assign sel_req   = mem_ready ? mem_req : alu_req;
    assign do_write  = any_grant && (sel_req.rd != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr  <= REQ_ALU;
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_rd   <= sel_req.rd;
                wr_data <= sel_req.data;
            end
            if (contended) rr_ptr <= alu_ready ? REQ_MEM : REQ_ALU;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_use_rd  (issue_use_rd),
        .issue_ready   (issue_ready),
        .clr_en        (do_write),
        .clr_rd        (sel_req.rd),
        .busy          (busy)
    );

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            conflict_count <= '0;
            stall_count    <= '0;
        end else begin
            if (contended)                 conflict_count <= conflict_count + 32'd1;
            if (issue_valid && !issue_ready) stall_count  <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; stats checks compile in when
// REGFILE_ARB_STATS_EN is defined.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                alu_valid, mem_valid, issue_valid;
    logic [ADDR_W-1:0]   alu_rd, mem_rd, issue_rs1, issue_rs2, issue_rd;
    logic [DATA_W-1:0]   alu_data, mem_data;
    logic                issue_use_rs1, issue_use_rs2, issue_use_rd;
    logic                alu_ready, mem_ready, issue_ready, wr_en;
    logic [ADDR_W-1:0]   wr_rd;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [31:0]         conflict_count, stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_use_rd  (issue_use_rd),
        .issue_ready   (issue_ready),
        .wr_rd         (wr_rd),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
`ifdef REGFILE_ARB_STATS_EN
        .conflict_count(conflict_count),
        .stall_count   (stall_count),
`endif
        .busy          (busy)
    );

    // Inputs change 1ns after the posedge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        issue_valid = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; issue_use_rd = 0;
    endtask

    task automatic issue_dest(input logic [ADDR_W-1:0] rd);
        issue_valid = 1; issue_use_rd = 1; issue_rd = rd;
        issue_use_rs1 = 0; issue_use_rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_rd !== '0 || wr_data !== '0) begin failures++; $display("FAIL reset_wr_regs got=%h/%h exp=0/0", wr_rd, wr_data); end
        issue_dest(5'd1); step();
        issue_dest(5'd2); step();
        issue_valid = 0;
        checks++; if (busy !== 32'h0000_0006) begin failures++; $display("FAIL pre_reset_busy got=%h exp=00000006", busy); end
        // Reset mid-traffic, with an ALU request waiting.
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        reset_n = 0;
        step(); step();
        reset_n = 1;
        checks++; if (busy !== '0) begin failures++; $display("FAIL midreset_busy got=%h exp=0", busy); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL midreset_wr_en got=%b exp=0", wr_en); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL midreset_alu_ready got=%b exp=1", alu_ready); end
        step();
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd9) begin failures++; $display("FAIL post_reset_write got=%b/%0d exp=1/9", wr_en, wr_rd); end
        idle_inputs();
        step();
    endtask

    task automatic test_single_write();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", alu_ready, mem_ready); end
        step();
        alu_valid = 0;
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", wr_en, wr_rd, wr_data); end
        step();
        checks++; if (wr_en !== 1'b0 || wr_rd !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef", wr_en, wr_rd, wr_data); end
    endtask

    task automatic test_contention();
        logic [DATA_W-1:0] a_dat, m_dat;
        logic              exp_mem;
        a_dat = 32'hA000_0000; m_dat = 32'hB000_0000;
        alu_valid = 1; alu_rd = 5'd1; mem_valid = 1; mem_rd = 5'd2;
        for (int k = 0; k < 4; k++) begin
            alu_data = a_dat; mem_data = m_dat;
            exp_mem = (k % 2) == 1;
            #1;
            checks++; if (alu_ready !== !exp_mem || mem_ready !== exp_mem) begin failures++; $display("FAIL contend_ready[%0d] got=%b%b exp=%b%b", k, alu_ready, mem_ready, !exp_mem, exp_mem); end
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_rd !== (exp_mem ? 5'd2 : 5'd1) || wr_data !== (exp_mem ? m_dat : a_dat)) begin
                failures++; $display("FAIL contend_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, wr_en, wr_rd, wr_data, exp_mem ? 2 : 1, exp_mem ? m_dat : a_dat);
            end
            // Only the winner presents new data; the loser holds.
            if (exp_mem) m_dat = m_dat + 1; else a_dat = a_dat + 1;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_raw_stall();
        issue_dest(5'd3);
        #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_first_issue got=%b exp=1", issue_ready); end
        step();
        checks++; if (busy !== 32'h0000_0008) begin failures++; $display("FAIL raw_busy_set got=%h exp=00000008", busy); end
        issue_use_rd = 0; issue_rd = '0; issue_use_rs1 = 1; issue_rs1 = 5'd3;
        #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall0 got=%b exp=0", issue_ready); end
        step();
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall1 got=%b exp=0", issue_ready); end
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        #1;
        checks++; if (issue_ready !== 1'b0 || alu_ready !== 1'b1) begin failures++; $display("FAIL raw_grant_cycle got=%b/%b exp=0/1", issue_ready, alu_ready); end
        step();
        alu_valid = 0;
        #1;
        checks++; if (issue_ready !== 1'b1 || busy !== '0) begin failures++; $display("FAIL raw_release got=%b/%h exp=1/0", issue_ready, busy); end
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd3) begin failures++; $display("FAIL raw_write got=%b/%0d exp=1/3", wr_en, wr_rd); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_set_over_clear();
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h7777_0007;
        issue_dest(5'd7);
        #1;
        checks++; if (issue_ready !== 1'b1 || mem_ready !== 1'b1) begin failures++; $display("FAIL soc_ready got=%b/%b exp=1/1", issue_ready, mem_ready); end
        step();
        idle_inputs();
        checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL soc_busy got=%h exp=00000080", busy); end
        checks++; if (wr_en !== 1'b1 || wr_rd !== 5'd7) begin failures++; $display("FAIL soc_write got=%b/%0d exp=1/7", wr_en, wr_rd); end
        // x0 writeback alongside an x0 issue with an x0 source.
        alu_valid = 1; alu_rd = '0; alu_data = 32'h0000_1234;
        issue_dest('0); issue_use_rs1 = 1; issue_rs1 = '0;
        #1;
        checks++; if (alu_ready !== 1'b1 || issue_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b/%b exp=1/1", alu_ready, issue_ready); end
        step();
        idle_inputs();
        checks++; if (wr_en !== 1'b0 || wr_rd !== 5'd7 || busy !== 32'h0000_0080) begin failures++; $display("FAIL x0_effect got=%b/%0d/%h exp=0/7/00000080", wr_en, wr_rd, busy); end
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0;
        step();
        idle_inputs();
        checks++; if (busy !== '0) begin failures++; $display("FAIL soc_cleanup got=%h exp=0", busy); end
        step();
    endtask

`ifdef REGFILE_ARB_STATS_EN
    task automatic test_stats();
        idle_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
        checks++; if (conflict_count !== 32'd0 || stall_count !== 32'd0) begin failures++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", conflict_count, stall_count); end
        alu_valid = 1; alu_rd = 5'd10; mem_valid = 1; mem_rd = 5'd11;
        step(); step(); step();
        idle_inputs();
        issue_dest(5'd4);
        step();
        issue_use_rd = 0; issue_rd = '0; issue_use_rs2 = 1; issue_rs2 = 5'd4;
        step(); step();
        idle_inputs();
        step();
        checks++; if (conflict_count !== 32'd3 || stall_count !== 32'd2) begin failures++; $display("FAIL stats_counts got=%0d/%0d exp=3/2", conflict_count, stall_count); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
        test_single_write();
        test_contention();
        test_raw_stall();
        test_set_over_clear();
`ifdef REGFILE_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
